// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: sequencer states, redirect kinds and the
// redirect target computation (also used by decode).
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  localparam logic REDIR_BRANCH = 1'b0;
  localparam logic REDIR_JUMP   = 1'b1;

  // Branch: pc+1 plus sign-extended 16-bit offset. Jump: keep top 6 bits of pc+1.
  function automatic logic [31:0] redirect_target(input logic        kind,
                                                  input logic [31:0] pc,
                                                  input logic [25:0] imm);
    logic [31:0] next_pc;
    next_pc = pc + 32'd1;
    if (kind == REDIR_JUMP) return {next_pc[31:26], imm};
    return next_pc + {{16{imm[15]}}, imm[15:0]};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction and its PC; clear wins over load.
module fetch_skid_buffer #(
  parameter int WIDTH_B = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [WIDTH_B-1:0] load_instr,
  input  logic [WIDTH_B-1:0] load_pc,
  output logic               held,
  output logic [WIDTH_B-1:0] held_instr,
  output logic [WIDTH_B-1:0] held_pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held       <= 1'b0;
      held_instr <= '0;
      held_pc    <= '0;
    end else if (clear) begin
      held <= 1'b0;
    end else if (load) begin
      held       <= 1'b1;
      held_instr <= load_instr;
      held_pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives a 1-cycle-latency ROM and
// hands instructions to decode over valid/ready, with redirect flush and skid.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int               WIDTH_B  = 32,
  parameter int               ADDR_B   = 10,
  parameter logic [WIDTH_B-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  output logic               rom_en,
  output logic [ADDR_B-1:0]  rom_addr,
  input  logic [WIDTH_B-1:0] rom_dout,
  input  logic               redirect_valid,
  input  logic               redirect_kind,
  input  logic [WIDTH_B-1:0] redirect_pc,
  input  logic [25:0]        redirect_imm,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [WIDTH_B-1:0] if_instr,
  output logic [WIDTH_B-1:0] if_pc,
  output logic [WIDTH_B-1:0] pc_debug
);

  fetch_state_t       state;
  logic [WIDTH_B-1:0] pc_q;
  logic               inflight_v;
  logic [WIDTH_B-1:0] inflight_pc;
  logic               skid_v;
  logic [WIDTH_B-1:0] skid_instr;
  logic [WIDTH_B-1:0] skid_pc;
  logic               issue;
  logic               stall_capture;
  logic [WIDTH_B-1:0] target;

  // The FLUSH cycle issues the redirect target so it is valid two cycles after the pulse.
  assign issue = (state == RUN || state == FLUSH) && fetch_en && !redirect_valid &&
                 !skid_v && (!inflight_v || if_ready);
  assign stall_capture = (state == RUN) && inflight_v && !if_ready && !redirect_valid;
  assign target        = redirect_target(redirect_kind, redirect_pc, redirect_imm);

  assign rom_en   = issue;
  assign rom_addr = pc_q[ADDR_B-1:0];
  assign pc_debug = pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc_q        <= RESET_PC;
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
    end else begin
      // Without a new issue the pending word is either accepted, moved to the skid, or flushed.
      inflight_v <= issue;
      if (issue) begin
        inflight_pc <= pc_q;
        pc_q        <= pc_q + WIDTH_B'(1);
      end
      if (redirect_valid) begin
        pc_q  <= target;
        state <= FLUSH;
      end else begin
        case (state)
          IDLE:    state <= RUN;
          RUN:     if (stall_capture) state <= HOLD;
          HOLD:    if (if_ready) state <= RUN;
          FLUSH:   state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

  fetch_skid_buffer #(.WIDTH_B(WIDTH_B)) u_skid (
    .clk        (clk),
    .rst        (reset),
    .load       (stall_capture),
    .clear      (redirect_valid | if_ready),
    .load_instr (rom_dout),
    .load_pc    (inflight_pc),
    .held       (skid_v),
    .held_instr (skid_instr),
    .held_pc    (skid_pc)
  );

  always_comb begin
    if_valid = skid_v | inflight_v;
    if_instr = '0;
    if_pc    = '0;
    if (skid_v) begin
      if_instr = skid_instr;
      if_pc    = skid_pc;
    end else if (inflight_v) begin
      if_instr = rom_dout;
      if_pc    = inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios, then random traffic checked
// against a stream-level model of the expected instruction sequence.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic [31:0] rom_dout;
  logic        redirect_valid;
  logic        redirect_kind;
  logic [31:0] redirect_pc;
  logic [25:0] redirect_imm;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] pc_debug;

  logic [31:0] rom_mem [0:1023];
  int          errors = 0;
  int          checks = 0;
  int          n_xfer = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.WIDTH_B(32), .ADDR_B(10), .RESET_PC(32'd0)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .rom_en         (rom_en),
    .rom_addr       (rom_addr),
    .rom_dout       (rom_dout),
    .redirect_valid (redirect_valid),
    .redirect_kind  (redirect_kind),
    .redirect_pc    (redirect_pc),
    .redirect_imm   (redirect_imm),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .pc_debug       (pc_debug)
  );

  always @(posedge clk) if (rom_en) rom_dout <= rom_mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_target(input logic kind, input logic [31:0] pc,
                                               input logic [25:0] imm);
    logic [31:0] seq_next;
    logic [31:0] offset;
    seq_next = pc + 32'd1;
    offset   = {{16{imm[15]}}, imm[15:0]};
    return kind ? {seq_next[31:26], imm} : seq_next + offset;
  endfunction

  // Stream model: what decode must receive, independent of how the sequencer gets there.
  logic [31:0] exp_pc;
  int          since_rst;
  logic        ok1, ok2, hold_prev, red1, red2;
  logic [31:0] prev_pc, prev_instr, red1_tgt, red2_tgt;

  always @(negedge clk) begin
    if (reset) begin
      exp_pc = 32'd0; since_rst = 0; ok1 = 0; ok2 = 0;
      hold_prev = 0; red1 = 0; red2 = 0;
    end else begin
      since_rst++;
      if (!if_valid) begin
        check("idle_pc", if_pc, 32'd0);
        check("idle_instr", if_instr, 32'd0);
      end
      check("rom_addr", 32'(rom_addr), 32'(pc_debug[9:0]));
      if (redirect_valid || !fetch_en) check("no_issue", 32'(rom_en), 32'd0);
      if (hold_prev) begin
        check("hold_v", 32'(if_valid), 32'd1);
        check("hold_pc", if_pc, prev_pc);
        check("hold_instr", if_instr, prev_instr);
      end
      if (red1) check("flush_v", 32'(if_valid), 32'd0);
      if (red2) begin
        check("redir_v", 32'(if_valid), 32'd1);
        check("redir_pc", if_pc, red2_tgt);
      end
      if (ok1 && ok2 && since_rst >= 4) check("live", 32'(if_valid), 32'd1);
      if (if_valid && if_ready) begin
        check("seq_pc", if_pc, exp_pc);
        check("seq_instr", if_instr, rom_mem[exp_pc[9:0]]);
        exp_pc = exp_pc + 32'd1;
        n_xfer++;
      end
      red2     = red1 && fetch_en && !redirect_valid;
      red2_tgt = red1_tgt;
      red1     = redirect_valid;
      if (redirect_valid) begin
        red1_tgt = model_target(redirect_kind, redirect_pc, redirect_imm);
        exp_pc   = red1_tgt;
      end
      hold_prev  = if_valid && !if_ready && !redirect_valid;
      prev_pc    = if_pc;
      prev_instr = if_instr;
      ok2 = ok1;
      ok1 = if_ready && fetch_en && !redirect_valid;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic kind, input logic [31:0] pc, input logic [25:0] imm);
    redirect_valid = 1'b1; redirect_kind = kind; redirect_pc = pc; redirect_imm = imm;
  endtask

  task automatic next_xfer(output logic [31:0] p, output logic [31:0] ins);
    int n;
    n = 0;
    cyc();
    while (!if_valid && n < 8) begin cyc(); n++; end
    check("xfer_timeout", 32'(if_valid), 32'd1);
    p = if_pc; ins = if_instr;
  endtask

  logic [31:0] p, ins;

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 32'h1000 + i;
    reset = 1'b1; fetch_en = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_kind = 1'b0; redirect_pc = '0; redirect_imm = '0;
    repeat (3) cyc();
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_rom_en", 32'(rom_en), 32'd0);
    check("rst_pc_q", pc_debug, 32'd0);

    // Stream from reset: first valid two clocks after release.
    fetch_en = 1'b1; if_ready = 1'b1; reset = 1'b0;
    cyc();
    check("first_gap", 32'(if_valid), 32'd0);
    check("first_rom_en", 32'(rom_en), 32'd1);
    cyc();
    check("first_v", 32'(if_valid), 32'd1);
    check("first_pc", if_pc, 32'd0);
    check("first_instr", if_instr, 32'h1000);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      check("b2b_v", 32'(if_valid), 32'd1);
      check("b2b_pc", if_pc, i);
      check("b2b_instr", if_instr, 32'h1000 + i);
    end

    // Stall at pc 5 for three cycles.
    if_ready = 1'b0;
    repeat (3) begin
      cyc();
      check("stall_pc", if_pc, 32'd5);
      check("stall_instr", if_instr, 32'h1005);
      check("stall_pc_q", pc_debug, 32'd6);
    end
    if_ready = 1'b1;
    #1 check("release_pc", if_pc, 32'd5);
    next_xfer(p, ins); check("after_stall_pc", p, 32'd6);
    next_xfer(p, ins); check("after_stall_pc2", p, 32'd7);
    next_xfer(p, ins); check("pre_branch_pc", p, 32'd8);

    // Branch from 8 with offset -4 -> 5; pc 9 never fetched.
    pulse(1'b0, 32'd8, 26'h3FFFC);
    #1 check("branch_no_issue", 32'(rom_en), 32'd0);
    cyc(); redirect_valid = 1'b0;
    #1 check("branch_flush_v", 32'(if_valid), 32'd0);
    check("branch_addr", 32'(rom_addr), 32'd5);
    cyc();
    check("branch_pc", if_pc, 32'd5);
    check("branch_instr", if_instr, 32'h1005);

    // Jump to 0x0400_0123.
    pulse(1'b1, 32'h0400_0010, 26'h0000123);
    cyc(); redirect_valid = 1'b0;
    #1 check("jump_pc_q", pc_debug, 32'h0400_0123);
    check("jump_addr", 32'(rom_addr), 32'h123);
    cyc();
    check("jump_pc", if_pc, 32'h0400_0123);
    check("jump_instr", if_instr, 32'h1123);

    // Redirect while holding: skid entry dropped, one empty FLUSH cycle.
    if_ready = 1'b0;
    cyc();
    check("hold_skid_pc", if_pc, 32'h0400_0123);
    pulse(1'b1, 32'h10, 26'h3FE);
    cyc(); redirect_valid = 1'b0;
    #1 check("hold_flush_v", 32'(if_valid), 32'd0);
    if_ready = 1'b1;
    cyc();
    check("wrap_pc0", if_pc, 32'h3FE);
    cyc();
    check("wrap_pc1", if_pc, 32'h3FF);
    check("wrap_addr", 32'(rom_addr), 32'd0);
    check("wrap_pc_q", pc_debug, 32'd1024);
    cyc();
    check("wrap_pc2", if_pc, 32'd1024);
    check("wrap_instr", if_instr, 32'h1000);

    // Reset mid-stream acts immediately.
    reset = 1'b1;
    #1 check("mid_rst_v", 32'(if_valid), 32'd0);
    check("mid_rst_rom_en", 32'(rom_en), 32'd0);
    check("mid_rst_pc_q", pc_debug, 32'd0);
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc();
    check("restart_pc", if_pc, 32'd0);
    check("restart_instr", if_instr, 32'h1000);

    // Random traffic against the stream model.
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
    cyc(); cyc();
    reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      cyc();
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1; redirect_valid = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
      end else begin
        fetch_en = ($urandom_range(0, 9) != 0);
        if_ready = ($urandom_range(0, 9) < 7);
        redirect_valid = ($urandom_range(0, 19) == 0);
        redirect_kind  = $urandom_range(0, 1) == 1;
        redirect_pc    = $urandom;
        redirect_imm   = 26'($urandom);
      end
    end
    redirect_valid = 1'b0;
    cyc(); cyc();
    check("xfer_count", 32'(n_xfer >= 1000), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
